// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle CPU controller: states, opcodes, funct codes,
// datapath select values and the decoded instruction class.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
`ifdef CTRL_ILLEGAL_TRAP_EN
      , S_HALT
`endif
   } state_t;

   typedef enum logic [3:0] {
      C_NOP,
      C_ADD,
      C_SUB,
      C_SLT,
      C_JR,
      C_LW,
      C_SW,
      C_J,
      C_JAL,
      C_BEQ,
      C_BNE,
      C_ADDI,
      C_XORI
   } instr_class_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // Must match the Lab 1 ALU command encoding
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_XOR = 3'd2;
   localparam logic [2:0] ALU_SLT = 3'd3;

   localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_REG    = 2'd3;

   localparam logic [1:0] REG_DST_RT  = 2'd0;
   localparam logic [1:0] REG_DST_RD  = 2'd1;
   localparam logic [1:0] REG_DST_R31 = 2'd2;

   localparam logic [1:0] WB_SRC_ALU   = 2'd0;
   localparam logic [1:0] WB_SRC_MEM   = 2'd1;
   localparam logic [1:0] WB_SRC_PCP4  = 2'd2;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle; the controller uses the slave modport,
// the datapath side (or a testbench) the master modport.
interface multicycle_control_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_we;
   logic       ir_write;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       reg_write;
   logic [1:0] reg_dst;
   logic [1:0] wb_src;
   logic       alu_src_b;
   logic       ext_sign;
   logic [2:0] alu_cmd;
   logic       instr_done;
   logic       halted;

   modport slave (
      input  opcode, funct, zero, mem_ready,
      output mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, reg_dst,
             wb_src, alu_src_b, ext_sign, alu_cmd, instr_done, halted
   );

   modport master (
      output opcode, funct, zero, mem_ready,
      input  mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, reg_dst,
             wb_src, alu_src_b, ext_sign, alu_cmd, instr_done, halted
   );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational instruction decoder: opcode/funct to instruction class plus a legal flag.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [5:0]   opcode,
   input  logic [5:0]   funct,
   output instr_class_t cls,
   output logic         legal
);
   always_comb begin
      cls   = C_NOP;
      legal = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  cls = C_ADD;
               FN_SUB:  cls = C_SUB;
               FN_SLT:  cls = C_SLT;
               FN_JR:   cls = C_JR;
               default: legal = 1'b0;
            endcase
         end
         OP_J:    cls = C_J;
         OP_JAL:  cls = C_JAL;
         OP_BEQ:  cls = C_BEQ;
         OP_BNE:  cls = C_BNE;
         OP_ADDI: cls = C_ADDI;
         OP_XORI: cls = C_XORI;
         OP_LW:   cls = C_LW;
         OP_SW:   cls = C_SW;
         default: legal = 1'b0;
      endcase
   end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset datapath.
// Define CTRL_ILLEGAL_TRAP_EN to halt on unsupported encodings instead of retiring them as NOPs.
module multicycle_control
   import cpu_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   multicycle_control_if.slave  bus
);
`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam state_t ILLEGAL_NEXT = S_HALT;
`else
   localparam state_t ILLEGAL_NEXT = S_EXEC;
`endif

   state_t       state_reg, state_next;
   instr_class_t cls_reg, cls_dec, cls;
   logic         legal;

   logic       mem_req, mem_we, ir_write, pc_write, reg_write, alu_src_b, ext_sign, done;
   logic [1:0] pc_src, reg_dst, wb_src;
   logic [2:0] alu_cmd;
   logic       taken;

   ctrl_decode u_decode (
      .opcode (bus.opcode),
      .funct  (bus.funct),
      .cls    (cls_dec),
      .legal  (legal)
   );

   // DECODE acts on the live instruction; later states use the latched class
   assign cls   = (state_reg == S_DECODE) ? cls_dec : cls_reg;
   assign taken = ((cls == C_BEQ) && bus.zero) || ((cls == C_BNE) && !bus.zero);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_FETCH;
         cls_reg   <= C_NOP;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_DECODE)
            cls_reg <= cls_dec;
      end
   end

   always_comb begin
      state_next = state_reg;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_SRC_PLUS4;
      reg_write  = 1'b0;
      reg_dst    = REG_DST_RT;
      wb_src     = WB_SRC_ALU;
      alu_src_b  = 1'b0;
      ext_sign   = 1'b0;
      alu_cmd    = ALU_ADD;
      done       = 1'b0;
      case (state_reg)
         S_FETCH: begin
            mem_req = 1'b1;
            if (bus.mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            case (cls)
               C_J: begin
                  pc_write   = 1'b1;
                  pc_src     = PC_SRC_JUMP;
                  done       = 1'b1;
                  state_next = S_FETCH;
               end
               C_JAL: begin
                  pc_write   = 1'b1;
                  pc_src     = PC_SRC_JUMP;
                  reg_write  = 1'b1;
                  reg_dst    = REG_DST_R31;
                  wb_src     = WB_SRC_PCP4;
                  done       = 1'b1;
                  state_next = S_FETCH;
               end
               default: state_next = legal ? S_EXEC : ILLEGAL_NEXT;
            endcase
         end
         S_EXEC: begin
            state_next = S_FETCH;
            case (cls)
               C_ADD: state_next = S_WB;
               C_SUB: begin alu_cmd = ALU_SUB; state_next = S_WB; end
               C_SLT: begin alu_cmd = ALU_SLT; state_next = S_WB; end
               C_ADDI: begin
                  alu_src_b  = 1'b1;
                  ext_sign   = 1'b1;
                  state_next = S_WB;
               end
               C_XORI: begin
                  alu_src_b  = 1'b1;
                  alu_cmd    = ALU_XOR;
                  state_next = S_WB;
               end
               C_LW, C_SW: begin
                  alu_src_b  = 1'b1;
                  ext_sign   = 1'b1;
                  state_next = S_MEM;
               end
               C_BEQ, C_BNE: begin
                  alu_cmd  = ALU_SUB;
                  pc_write = taken;
                  pc_src   = taken ? PC_SRC_BRANCH : PC_SRC_PLUS4;
                  done     = 1'b1;
               end
               C_JR: begin
                  pc_write = 1'b1;
                  pc_src   = PC_SRC_REG;
                  done     = 1'b1;
               end
               default: done = 1'b1;
            endcase
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = (cls == C_SW);
            if (bus.mem_ready) begin
               done       = (cls == C_SW);
               state_next = (cls == C_SW) ? S_FETCH : S_WB;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            done       = 1'b1;
            state_next = S_FETCH;
            case (cls)
               C_ADD, C_SUB, C_SLT: reg_dst = REG_DST_RD;
               C_LW:                wb_src  = WB_SRC_MEM;
               default: ;
            endcase
         end
         default: state_next = state_reg;
      endcase
      // Reset suppresses every strobe in the same cycle, aborting any access in flight
      if (reset) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         ir_write  = 1'b0;
         pc_write  = 1'b0;
         pc_src    = PC_SRC_PLUS4;
         reg_write = 1'b0;
         reg_dst   = REG_DST_RT;
         wb_src    = WB_SRC_ALU;
         alu_src_b = 1'b0;
         ext_sign  = 1'b0;
         alu_cmd   = ALU_ADD;
         done      = 1'b0;
      end
   end

   assign bus.mem_req    = mem_req;
   assign bus.mem_we     = mem_we;
   assign bus.ir_write   = ir_write;
   assign bus.pc_write   = pc_write;
   assign bus.pc_src     = pc_src;
   assign bus.reg_write  = reg_write;
   assign bus.reg_dst    = reg_dst;
   assign bus.wb_src     = wb_src;
   assign bus.alu_src_b  = alu_src_b;
   assign bus.ext_sign   = ext_sign;
   assign bus.alu_cmd    = alu_cmd;
   assign bus.instr_done = done;
`ifdef CTRL_ILLEGAL_TRAP_EN
   assign bus.halted     = (state_reg == S_HALT) && !reset;
`else
   assign bus.halted     = 1'b0;
`endif
endmodule
